// File: rtl/la_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// la_cmd_sequencer
// Command sequencer sitting between the logic-analyzer probes and the user
// datapath counter. The host issues commands with a toggle handshake on
// la_data_in[0]. Each accepted command is decoded and acknowledged with
// exactly one flip of the ack bit on la_data_out.
//
// Ports
//   wb_clk_i       clock
//   wb_rst_i       asynchronous, active-high reset
//   la_data_in     [0] cmd toggle, [3:1] opcode, [4 +: BITS] operand
//   la_data_out    [31:0] result, [32] ack toggle, [33] busy, [34] run_mode,
//                  [35] err_illegal, [36] err_overrun, [38:37] state, rest 0
//   dp_load        one-cycle load strobe to the datapath
//   dp_load_value  value presented with dp_load
//   dp_en          datapath count enable
//   dp_count       current datapath count
// -----------------------------------------------------------------------------
module la_cmd_sequencer #(
  parameter int BITS        = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [127:0]     la_data_in,
  output logic [127:0]     la_data_out,
  output logic             dp_load,
  output logic [BITS-1:0]  dp_load_value,
  output logic             dp_en,
  input  logic [BITS-1:0]  dp_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    STEP = 2'd2,
    ACK  = 2'd3
  } state_t;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_RUN  = 3'd2;
  localparam logic [2:0] OP_STOP = 3'd3;
  localparam logic [2:0] OP_STEP = 3'd4;
  localparam logic [2:0] OP_READ = 3'd5;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  state_t                 state_q, state_d;
  logic [2:0]             opcode_q, opcode_d;
  logic [BITS-1:0]        operand_q, operand_d;
  logic [BITS-1:0]        stepCnt_q, stepCnt_d;
  logic [31:0]            result_q, result_d;
  logic                   ack_q, ack_d;
  logic                   runMode_q, runMode_d;
  logic                   errIllegal_q, errIllegal_d;
  logic                   errOverrun_q, errOverrun_d;
  logic                   cmdEdge;
  logic                   busy;

  // Operand bits above the datapath width and the upper probe bits carry
  // nothing for this block; folding them here keeps them visibly consumed.
  logic unusedLaBits;
  assign unusedLaBits = ^la_data_in[127:4+BITS];

  // The toggle is asynchronous to our clock, so it is synchronised first.
  // prev tracks the synchronised level every cycle, even while busy, so a
  // dropped command never resurfaces later as a stale edge.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], la_data_in[0]};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign cmdEdge = sync_q[SYNC_STAGES-1] ^ prev_q;
  assign busy    = (state_q != IDLE);

  // State and command registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      opcode_q     <= '0;
      operand_q    <= '0;
      stepCnt_q    <= '0;
      result_q     <= '0;
      ack_q        <= 1'b0;
      runMode_q    <= 1'b0;
      errIllegal_q <= 1'b0;
      errOverrun_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      operand_q    <= operand_d;
      stepCnt_q    <= stepCnt_d;
      result_q     <= result_d;
      ack_q        <= ack_d;
      runMode_q    <= runMode_d;
      errIllegal_q <= errIllegal_d;
      errOverrun_q <= errOverrun_d;
    end
  end

  // Next-state and command decode. Opcodes are only acted on in EXEC so that
  // every command, legal or not, walks through ACK and flips ack exactly once.
  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    operand_d     = operand_q;
    stepCnt_d     = stepCnt_q;
    result_d      = result_q;
    ack_d         = ack_q;
    runMode_d     = runMode_q;
    errIllegal_d  = errIllegal_q;
    errOverrun_d  = errOverrun_q;
    dp_load       = 1'b0;
    dp_load_value = '0;

    case (state_q)
      IDLE: begin
        if (cmdEdge) begin
          opcode_d  = la_data_in[3:1];
          operand_d = la_data_in[4 +: BITS];
          state_d   = EXEC;
        end
      end
      EXEC: begin
        state_d = ACK;
        case (opcode_q)
          OP_NOP: begin
            errIllegal_d = 1'b0;
            errOverrun_d = 1'b0;
          end
          OP_LOAD: begin
            dp_load       = 1'b1;
            dp_load_value = operand_q;
          end
          OP_RUN:  runMode_d = 1'b1;
          OP_STOP: runMode_d = 1'b0;
          OP_STEP: begin
            // A burst on top of free-running makes no sense; flag it instead.
            if (runMode_q) begin
              errIllegal_d = 1'b1;
            end else if (operand_q != '0) begin
              stepCnt_d = operand_q;
              state_d   = STEP;
            end
          end
          OP_READ: result_d = 32'(dp_count);
          default: errIllegal_d = 1'b1;
        endcase
      end
      STEP: begin
        stepCnt_d = stepCnt_q - BITS'(1);
        if (stepCnt_q == BITS'(1)) begin
          state_d = ACK;
        end
      end
      ACK: begin
        ack_d   = ~ack_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // An edge arriving while busy is dropped; recording it last lets it win
    // over a NOP clearing the flags in the same cycle.
    if (cmdEdge && busy) begin
      errOverrun_d = 1'b1;
    end
  end

  assign dp_en = runMode_q | (state_q == STEP);

  assign la_data_out = {89'd0, state_q, errOverrun_q, errIllegal_q, runMode_q,
                        busy, ack_q, result_q};

endmodule

// File: tb/tb_la_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_la_cmd_sequencer
// Directed bench for la_cmd_sequencer with a simple load/count datapath model
// hanging off the dp_* ports. Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_la_cmd_sequencer;

  logic         clk;
  logic         rst;
  logic [127:0] laIn;
  logic [127:0] laOut;
  logic         dpLoad;
  logic [31:0]  dpLoadValue;
  logic         dpEn;
  logic [31:0]  dpCount;

  int total = 0;
  int bad   = 0;
  int enCount = 0;
  int loadCount = 0;
  logic [31:0] lastLoadValue = '0;
  logic expAck = 1'b0;

  la_cmd_sequencer #(.BITS(32), .SYNC_STAGES(2)) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .la_data_in    (laIn),
    .la_data_out   (laOut),
    .dp_load       (dpLoad),
    .dp_load_value (dpLoadValue),
    .dp_en         (dpEn),
    .dp_count      (dpCount)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-in: load has priority over count enable.
  always @(posedge clk or posedge rst) begin
    if (rst) dpCount <= '0;
    else if (dpLoad) dpCount <= dpLoadValue;
    else if (dpEn) dpCount <= dpCount + 32'd1;
  end

  // Tally enable cycles and load strobes as seen mid-cycle.
  always @(negedge clk) begin
    if (dpEn) enCount++;
    if (dpLoad) begin
      loadCount++;
      lastLoadValue = dpLoadValue;
    end
  end

  // Hard stop in case something wedges the sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present opcode/operand, flip the toggle a cycle later, then wait for the
  // ack flip and check how many cycles it took.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] operand,
                               input int expLatency, input string tag);
    int lat;
    bit seen;
    @(negedge clk);
    laIn[3:1]  = op;
    laIn[35:4] = operand;
    @(negedge clk);
    laIn[0] = ~laIn[0];
    expAck  = ~expAck;
    lat  = 0;
    seen = 0;
    while (!seen && lat < expLatency + 20) begin
      @(negedge clk);
      lat++;
      if (laOut[32] == expAck) seen = 1;
    end
    checkOutput({tag, "_ack"}, 128'(laOut[32]), 128'(expAck));
    checkOutput({tag, "_lat"}, 128'(lat), 128'(expLatency));
  endtask

  initial begin
    int enStart;
    int lat;
    bit seen;

    $display("[TB] starting la_cmd_sequencer bench");
    laIn = '0;
    rst  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset release with the toggle held low: nothing happens.
    repeat (8) @(negedge clk);
    checkOutput("reset_laOut", laOut, 128'd0);
    checkOutput("reset_dpEn", 128'(dpEn), 128'd0);
    checkOutput("reset_dpLoad", 128'(dpLoad), 128'd0);
    checkOutput("reset_loadValue", 128'(dpLoadValue), 128'd0);

    // LOAD then READ back.
    applyStimulus(3'd1, 32'h1234, 5, "load");
    checkOutput("load_pulses", 128'(loadCount), 128'd1);
    checkOutput("load_value", 128'(lastLoadValue), 128'h1234);
    applyStimulus(3'd5, 32'h0, 5, "read1");
    checkOutput("read1_result", 128'(laOut[31:0]), 128'h1234);

    // STEP 5 then STEP 0.
    enStart = enCount;
    applyStimulus(3'd4, 32'd5, 10, "step5");
    checkOutput("step5_enCycles", 128'(enCount - enStart), 128'd5);
    applyStimulus(3'd5, 32'h0, 5, "read2");
    checkOutput("read2_result", 128'(laOut[31:0]), 128'h1239);
    enStart = enCount;
    applyStimulus(3'd4, 32'd0, 5, "step0");
    checkOutput("step0_enCycles", 128'(enCount - enStart), 128'd0);
    checkOutput("step0_busy", 128'(laOut[33]), 128'd0);

    // RUN for 100 cycles, then STOP.
    applyStimulus(3'd2, 32'h0, 5, "run");
    checkOutput("run_mode_on", 128'(laOut[34]), 128'd1);
    enStart = enCount;
    repeat (100) @(negedge clk);
    checkOutput("run_enCycles", 128'(enCount - enStart), 128'd100);
    applyStimulus(3'd3, 32'h0, 5, "stop");
    checkOutput("run_mode_off", 128'(laOut[34]), 128'd0);
    enStart = enCount;
    repeat (10) @(negedge clk);
    checkOutput("stop_enCycles", 128'(enCount - enStart), 128'd0);

    // Illegal opcode, NOP clear, STEP while running.
    applyStimulus(3'd7, 32'h0, 5, "op7");
    checkOutput("op7_errIllegal", 128'(laOut[35]), 128'd1);
    applyStimulus(3'd0, 32'h0, 5, "nop1");
    checkOutput("nop1_errIllegal", 128'(laOut[35]), 128'd0);
    applyStimulus(3'd2, 32'h0, 5, "run2");
    applyStimulus(3'd4, 32'd3, 5, "stepRun");
    checkOutput("stepRun_errIllegal", 128'(laOut[35]), 128'd1);
    applyStimulus(3'd3, 32'h0, 5, "stop2");
    enStart = enCount;
    repeat (10) @(negedge clk);
    checkOutput("stop2_enCycles", 128'(enCount - enStart), 128'd0);
    applyStimulus(3'd0, 32'h0, 5, "nop2");
    checkOutput("nop2_errIllegal", 128'(laOut[35]), 128'd0);

    // Second toggle during STEP 50 is dropped and flagged.
    @(negedge clk);
    laIn[3:1]  = 3'd4;
    laIn[35:4] = 32'd50;
    @(negedge clk);
    enStart = enCount;
    laIn[0] = ~laIn[0];
    expAck  = ~expAck;
    repeat (10) @(negedge clk);
    checkOutput("step50_busy", 128'(laOut[33]), 128'd1);
    checkOutput("step50_state", 128'(laOut[38:37]), 128'd2);
    laIn[0] = ~laIn[0];
    lat  = 10;
    seen = 0;
    while (!seen && lat < 80) begin
      @(negedge clk);
      lat++;
      if (laOut[32] == expAck) seen = 1;
    end
    checkOutput("step50_ack", 128'(laOut[32]), 128'(expAck));
    checkOutput("step50_lat", 128'(lat), 128'd55);
    repeat (20) @(negedge clk);
    checkOutput("overrun_noSecondAck", 128'(laOut[32]), 128'(expAck));
    checkOutput("overrun_flag", 128'(laOut[36]), 128'd1);
    checkOutput("step50_enCycles", 128'(enCount - enStart), 128'd50);
    applyStimulus(3'd0, 32'h0, 5, "nop3");
    checkOutput("nop3_errOverrun", 128'(laOut[36]), 128'd0);

    // Async reset in the middle of a STEP 50 burst.
    @(negedge clk);
    laIn[3:1]  = 3'd4;
    laIn[35:4] = 32'd50;
    @(negedge clk);
    enStart = enCount;
    laIn[0] = ~laIn[0];
    lat = 0;
    while ((enCount - enStart) < 20 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("abort_reached20", 128'(enCount - enStart), 128'd20);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_laOut", laOut, 128'd0);
    checkOutput("abort_dpEn", 128'(dpEn), 128'd0);
    laIn   = '0;
    expAck = 1'b0;
    enStart = enCount;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("abort_noAck", laOut, 128'd0);
    checkOutput("abort_enCycles", 128'(enCount - enStart), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
